// File: rtl/pc_gen_pkg.sv
// Shared types for the fetch-stage program counter: FSM states, redirect
// source encoding (ordered by priority) and the replacement rule.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_PEND = 2'd2
  } state_e;

  // Numeric order is priority order: a larger value outranks a smaller one.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_TRAP = 2'd2
  } redir_src_e;

  // A new redirect replaces the held one when it is at least as urgent.
  // Equal priority wins so the newest request of a kind is the one kept.
  function automatic logic redir_wins(redir_src_e new_src, redir_src_e held_src);
    return (new_src != SRC_NONE) && (new_src >= held_src);
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Combinational trap-over-branch select. The single winner feeds both the
// direct-load path and the pending-replacement path of pc_gen.
module pc_redirect_arb
  import pc_gen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             br_en,
  input  logic [WIDTH-1:0] br_target,
  input  logic             trap_en,
  input  logic [WIDTH-1:0] trap_target,
  output logic             req_valid,
  output logic [WIDTH-1:0] req_target,
  output redir_src_e       req_src
);

  // Trap always outranks branch; a simultaneous branch is discarded.
  always_comb begin
    req_valid  = 1'b0;
    req_target = '0;
    req_src    = SRC_NONE;
    if (trap_en) begin
      req_valid  = 1'b1;
      req_target = trap_target;
      req_src    = SRC_TRAP;
    end else if (br_en) begin
      req_valid  = 1'b1;
      req_target = br_target;
      req_src    = SRC_BR;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: reset vector, sequential increment, stall hold,
// trap/branch redirects and a pending-redirect slot so a redirect seen while
// stalled is applied on the first non-stalled edge.
// Optional build macro PC_GEN_MISALIGN_CHECK_EN adds misalign_err and rejects
// redirect targets whose low two bits are nonzero.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               INC         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             br_en,
  input  logic [WIDTH-1:0] br_target,
  input  logic             trap_en,
  input  logic [WIDTH-1:0] trap_target,
`ifdef PC_GEN_MISALIGN_CHECK_EN
  output logic             misalign_err,
`endif
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic             redirect_taken,
  output logic             pend
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  state_e           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic             pc_valid_reg, pc_valid_next;
  logic             taken_reg, taken_next;
  logic [WIDTH-1:0] pend_target_reg, pend_target_next;
  redir_src_e       pend_src_reg, pend_src_next;

  logic             arb_valid;
  logic [WIDTH-1:0] arb_target;
  redir_src_e       arb_src;
  logic             req_ok;

  pc_redirect_arb #(.WIDTH(WIDTH)) u_arb (
    .br_en       (br_en),
    .br_target   (br_target),
    .trap_en     (trap_en),
    .trap_target (trap_target),
    .req_valid   (arb_valid),
    .req_target  (arb_target),
    .req_src     (arb_src)
  );

`ifdef PC_GEN_MISALIGN_CHECK_EN
  logic misalign_reg, misalign_next;
  logic req_bad;
  // A misaligned winner is treated as if no redirect had been requested.
  assign req_ok  = arb_valid && (arb_target[1:0] == 2'b00);
  assign req_bad = arb_valid && (arb_target[1:0] != 2'b00);
  assign misalign_err = misalign_reg;
`else
  assign req_ok = arb_valid;
`endif

  // Next-state, next-pc and pending-slot decisions for the current edge.
  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    pc_valid_next    = pc_valid_reg;
    taken_next       = 1'b0;
    pend_target_next = pend_target_reg;
    pend_src_next    = pend_src_reg;
`ifdef PC_GEN_MISALIGN_CHECK_EN
    misalign_next    = 1'b0;
`endif
    case (state_reg)
      S_BOOT: begin
        state_next    = S_RUN;
        pc_valid_next = 1'b1;
      end
      S_RUN: begin
        if (req_ok) begin
          if (!stall) begin
            pc_next    = arb_target;
            taken_next = 1'b1;
          end else begin
            pend_target_next = arb_target;
            pend_src_next    = arb_src;
            state_next       = S_PEND;
          end
        end else if (!stall) begin
          pc_next = pc_reg + INC_W;
        end
`ifdef PC_GEN_MISALIGN_CHECK_EN
        misalign_next = req_bad;
`endif
      end
      S_PEND: begin
        if (req_ok && redir_wins(arb_src, pend_src_reg)) begin
          if (!stall) begin
            pc_next          = arb_target;
            taken_next       = 1'b1;
            pend_target_next = '0;
            pend_src_next    = SRC_NONE;
            state_next       = S_RUN;
          end else begin
            pend_target_next = arb_target;
            pend_src_next    = arb_src;
          end
        end else if (!stall) begin
          pc_next          = pend_target_reg;
          taken_next       = 1'b1;
          pend_target_next = '0;
          pend_src_next    = SRC_NONE;
          state_next       = S_RUN;
        end
`ifdef PC_GEN_MISALIGN_CHECK_EN
        misalign_next = req_bad && redir_wins(arb_src, pend_src_reg);
`endif
      end
      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  // State register; reset overrides everything including a held redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_BOOT;
      pc_reg          <= RESET_VALUE;
      pc_valid_reg    <= 1'b0;
      taken_reg       <= 1'b0;
      pend_target_reg <= '0;
      pend_src_reg    <= SRC_NONE;
`ifdef PC_GEN_MISALIGN_CHECK_EN
      misalign_reg    <= 1'b0;
`endif
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      pc_valid_reg    <= pc_valid_next;
      taken_reg       <= taken_next;
      pend_target_reg <= pend_target_next;
      pend_src_reg    <= pend_src_next;
`ifdef PC_GEN_MISALIGN_CHECK_EN
      misalign_reg    <= misalign_next;
`endif
    end
  end

  assign pc             = pc_reg;
  assign pc_valid       = pc_valid_reg;
  assign redirect_taken = taken_reg;
  assign pend           = (state_reg == S_PEND);

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: main instance with reset vector 0x100 and a second
// instance at 0xFFFF_FFF8 that shows modulo wrap of the increment.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall, br_en, trap_en;
  logic [31:0] br_target, trap_target;
  logic [31:0] pc, pc_w;
  logic        pc_valid, redirect_taken, pend;
  logic        pc_valid_w, redirect_taken_w, pend_w;
`ifdef PC_GEN_MISALIGN_CHECK_EN
  logic        misalign_err, misalign_err_w;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_gen #(.WIDTH(32), .RESET_VALUE(32'h0000_0100), .INC(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .br_en          (br_en),
    .br_target      (br_target),
    .trap_en        (trap_en),
    .trap_target    (trap_target),
`ifdef PC_GEN_MISALIGN_CHECK_EN
    .misalign_err   (misalign_err),
`endif
    .pc             (pc),
    .pc_valid       (pc_valid),
    .redirect_taken (redirect_taken),
    .pend           (pend)
  );

  pc_gen #(.WIDTH(32), .RESET_VALUE(32'hFFFF_FFF8), .INC(4)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .stall          (1'b0),
    .br_en          (1'b0),
    .br_target      (32'h0),
    .trap_en        (1'b0),
    .trap_target    (32'h0),
`ifdef PC_GEN_MISALIGN_CHECK_EN
    .misalign_err   (misalign_err_w),
`endif
    .pc             (pc_w),
    .pc_valid       (pc_valid_w),
    .redirect_taken (redirect_taken_w),
    .pend           (pend_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic e_valid,
                           input logic e_taken, input logic e_pend);
    chk({tag, ".pc"},    pc,                       e_pc);
    chk({tag, ".valid"}, {31'b0, pc_valid},        {31'b0, e_valid});
    chk({tag, ".taken"}, {31'b0, redirect_taken},  {31'b0, e_taken});
    chk({tag, ".pend"},  {31'b0, pend},            {31'b0, e_pend});
    $display("step %-14s pc=%h valid=%0b taken=%0b pend=%0b", tag, pc, pc_valid, redirect_taken, pend);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; br_en = 1'b0; trap_en = 1'b0;
    br_target = 32'h0; trap_target = 32'h0;

    // Reset state on both instances.
    step();
    chk_state("reset", 32'h100, 1'b0, 1'b0, 1'b0);
    chk("wrap_reset.pc", pc_w, 32'hFFFF_FFF8);
    chk("wrap_reset.valid", {31'b0, pc_valid_w}, 32'h0);
    rst = 1'b0;

    // Boot cycle then sequential fetch.
    step(); chk_state("boot", 32'h100, 1'b1, 1'b0, 1'b0);
    chk("wrap0.pc", pc_w, 32'hFFFF_FFF8);
    step(); chk_state("seq1", 32'h104, 1'b1, 1'b0, 1'b0);
    chk("wrap1.pc", pc_w, 32'hFFFF_FFFC);
    step(); chk_state("seq2", 32'h108, 1'b1, 1'b0, 1'b0);
    chk("wrap2.pc", pc_w, 32'h0000_0000);
    step(); chk_state("seq3", 32'h10C, 1'b1, 1'b0, 1'b0);

    // Unstalled branch: one-edge latency, one-cycle pulse.
    br_en = 1'b1; br_target = 32'h2000;
    step(); chk_state("br", 32'h2000, 1'b1, 1'b1, 1'b0);
    br_en = 1'b0;
    step(); chk_state("br_next", 32'h2004, 1'b1, 1'b0, 1'b0);

    // Branch during stall, then trap replaces it while still stalled.
    stall = 1'b1; br_en = 1'b1; br_target = 32'h3000;
    step(); chk_state("st_br", 32'h2004, 1'b1, 1'b0, 1'b1);
    br_en = 1'b0; trap_en = 1'b1; trap_target = 32'h80;
    step(); chk_state("st_trap", 32'h2004, 1'b1, 1'b0, 1'b1);
    trap_en = 1'b0;
    step(); chk_state("st_idle", 32'h2004, 1'b1, 1'b0, 1'b1);
    stall = 1'b0;
    step(); chk_state("st_release", 32'h80, 1'b1, 1'b1, 1'b0);
    step(); chk_state("post_trap", 32'h84, 1'b1, 1'b0, 1'b0);

    // Trap pending; a later branch is lower priority and dropped.
    stall = 1'b1; trap_en = 1'b1; trap_target = 32'h80;
    step(); chk_state("tp_hold", 32'h84, 1'b1, 1'b0, 1'b1);
    trap_en = 1'b0; br_en = 1'b1; br_target = 32'h4000;
    step(); chk_state("tp_br_drop", 32'h84, 1'b1, 1'b0, 1'b1);
    br_en = 1'b0; stall = 1'b0;
    step(); chk_state("tp_release", 32'h80, 1'b1, 1'b1, 1'b0);

    // Same-cycle trap and branch: trap wins.
    trap_en = 1'b1; trap_target = 32'h500; br_en = 1'b1; br_target = 32'h600;
    step(); chk_state("arb", 32'h500, 1'b1, 1'b1, 1'b0);
    trap_en = 1'b0; br_en = 1'b0;
    step(); chk_state("arb_next", 32'h504, 1'b1, 1'b0, 1'b0);

    // Pending branch replaced by a newer branch arriving on the release edge.
    stall = 1'b1; br_en = 1'b1; br_target = 32'h1000;
    step(); chk_state("bb_hold", 32'h504, 1'b1, 1'b0, 1'b1);
    stall = 1'b0; br_target = 32'h1100;
    step(); chk_state("bb_direct", 32'h1100, 1'b1, 1'b1, 1'b0);
    br_en = 1'b0;
    step(); chk_state("bb_next", 32'h1104, 1'b1, 1'b0, 1'b0);

    // Reset with a redirect pending; boot cycle ignores stall and redirect.
    stall = 1'b1; br_en = 1'b1; br_target = 32'h7000;
    step(); chk_state("rp_hold", 32'h1104, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    step(); chk_state("rp_reset", 32'h100, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(); chk_state("rp_boot", 32'h100, 1'b1, 1'b0, 1'b0);
    stall = 1'b0; br_en = 1'b0;
    step(); chk_state("rp_seq", 32'h104, 1'b1, 1'b0, 1'b0);

`ifdef PC_GEN_MISALIGN_CHECK_EN
    // Misaligned branch target: not taken, error pulse, normal increment.
    br_en = 1'b1; br_target = 32'h2002;
    step(); chk_state("mis", 32'h108, 1'b1, 1'b0, 1'b0);
    chk("mis.err", {31'b0, misalign_err}, 32'h1);
    br_en = 1'b0;
    step(); chk_state("mis_next", 32'h10C, 1'b1, 1'b0, 1'b0);
    chk("mis_next.err", {31'b0, misalign_err}, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
